apb_req_arbiter: RTL
====================

// Module: apb_req_arbiter
// PURPOSE
//  Shares the single APB master request interface between two requesters:
//  port 0 = processor, port 1 = secondary bus agent (DMA/debug loader).
//  One transfer is outstanding at a time. Grants are round-robin and
//  registered. Sits between the requesters and the APB master's
//  wr_en/rd_en/done interface. Addr bit [8] selects the peripheral (psel).
// PARAMETERS
//  ADDR_W          9   request/APB address width
//  DATA_W          16  data width
//  TIMEOUT_CYCLES  64  WAIT cycles before abort (APB_ARB_TIMEOUT_EN only); >=2
// PORTS
//  clk        in   1       clock, all logic posedge
//  nreset     in   1       synchronous, active-low reset
//  rq_en      in   2       per-requester request; level, held until rq_done
//  rq_write   in   2       per-requester: 1 = write, 0 = read
//  rq_addr0   in   ADDR_W  requester 0 address
//  rq_addr1   in   ADDR_W  requester 1 address
//  rq_wdata0  in   DATA_W  requester 0 write data
//  rq_wdata1  in   DATA_W  requester 1 write data
//  rq_done    out  2       one-cycle completion pulse, per requester
//  rq_rdata   out  DATA_W  read data; valid while a rq_done bit is high
//  rq_err     out  1       abort flag; qualifies rq_done (timeout build only)
//  wr_en      out  1       to APB master: write request
//  wr_addr    out  ADDR_W  to APB master
//  wr_data    out  DATA_W  to APB master
//  wr_done    in   1       from APB master: write complete
//  rd_en      out  1       to APB master: read request
//  rd_addr    out  ADDR_W  to APB master
//  rd_data    in   DATA_W  from APB master
//  rd_done    in   1       from APB master: read complete
//  grant_id   out  1       requester owning the master (valid when busy)
//  busy       out  1       high in ISSUE/WAIT/RESP
// BEHAVIOUR
//  - All outputs are registered. On reset: wr_en=rd_en=0; addr/data=0;
//    rq_done=0; rq_rdata=0; rq_err=0; busy=0; grant_id=0; state=IDLE;
//    last=1 (port 0 wins the first contention).
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if any rq_en bit is set, pick the winner and latch its
//    write/addr/wdata; move to ISSUE. If none is set, stay.
//  - Arbitration: if only one requester is active, it wins. If both are
//    active, the port != last wins. Set last <= winner at grant.
//  - ISSUE: assert wr_en or rd_en with the latched addr/data. Go to WAIT.
//    Request-to-en latency is 2 clk from the rq_en sample in IDLE.
//  - WAIT: hold en, addr and data stable. Only the done input matching the
//    op type counts (wr_done for writes, rd_done for reads). The other
//    done input is ignored.
//  - On a matching done: drop en next edge; capture rd_data (reads);
//    go to RESP.
//  - RESP: pulse rq_done[grant] for exactly one cycle with rq_rdata valid;
//    rq_rdata holds its value until the next read.
//  - Requester handshake: deassert rq_en by the cycle after rq_done.
//    If rq_en is still high in IDLE, it is a new request.
//  - rq_en changes on a non-granted port never disturb a transfer in flight.
//  - Requester addr/data are sampled only at grant; later changes are ignored.
//  - Reset mid-transfer: return to IDLE immediately and drop en. No
//    rq_done is issued. The APB master is reset on the same nreset.
//  - Never: both wr_en and rd_en high; two rq_done bits high; en high in IDLE.
// CONFIGURATION
//  APB_ARB_TIMEOUT_EN defined:
//    - A cycle counter starts at 0 on WAIT entry.
//    - If the counter reaches TIMEOUT_CYCLES with no matching done: drop en,
//      go to RESP, pulse rq_done with rq_err=1 and rq_rdata=16'hDEAD.
//    - A late done arriving in IDLE is ignored.
//  Not defined:
//    - WAIT persists until done arrives; no counter is built.
//    - rq_err is tied to 0.
// TESTING
//  1 Read: port0 rd addr 9'h005; master rd_done +3 clk with 16'h1234 ->
//    rd_en high 2 clk after grant, rq_done=2'b01, rq_rdata=16'h1234.
//  2 Write: port1 wr addr 9'h100 (psel2), data 16'hBEEF -> wr_addr/wr_data
//    match and hold until wr_done; then rq_done=2'b10.
//  3 Contention: both ports request continuously for 6 transfers after
//    reset -> grants go 0,1,0,1,0,1.
//  4 Wrong done: write in flight, rd_done pulses -> ignored, stay in WAIT;
//    the following wr_done completes the write.
//  5 Reset during WAIT -> next cycle en=0, busy=0, no rq_done. The next
//    request is granted normally.
//  6 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, master silent -> at WAIT+8:
//    rq_done=1, rq_err=1, rq_rdata=16'hDEAD.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Two-port round-robin arbiter in front of a single APB master wr/rd request interface.
// Optional build macro APB_ARB_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT_CYCLES.
module apb_req_arbiter #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [1:0]        rq_en,
    input  logic [1:0]        rq_write,
    input  logic [ADDR_W-1:0] rq_addr0,
    input  logic [ADDR_W-1:0] rq_addr1,
    input  logic [DATA_W-1:0] rq_wdata0,
    input  logic [DATA_W-1:0] rq_wdata1,
    output logic [1:0]        rq_done,
    output logic [DATA_W-1:0] rq_rdata,
    output logic              rq_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_done,
    output logic              grant_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              grant_q, grant_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              winner;
    logic              match_done;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // With both ports asking, the one that did not win last time takes it.
    assign winner     = (&rq_en) ? ~last_q : rq_en[1];
    assign match_done = write_q ? wr_done : rd_done;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_en_d = wr_en_q;
        rd_en_d = rd_en_q;
        done_d  = 2'b00;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        busy_d  = busy_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|rq_en) begin
                    grant_d = winner;
                    last_d  = winner;
                    write_d = rq_write[winner];
                    addr_d  = winner ? rq_addr1 : rq_addr0;
                    wdata_d = winner ? rq_wdata1 : rq_wdata0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wr_en_d = write_q;
                rd_en_d = ~write_q;
                state_d = S_WAIT;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (match_done) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    if (!write_q) begin
                        rdata_d = rd_data;
                    end
                    done_d  = grant_q ? 2'b10 : 2'b01;
                    state_d = S_RESP;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    rdata_d = DATA_W'(16'hDEAD);
                    err_d   = 1'b1;
                    done_d  = grant_q ? 2'b10 : 2'b01;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 2'b00;
            rdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign rq_done  = done_q;
    assign rq_rdata = rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    assign rq_err   = err_q;
`else
    assign rq_err   = 1'b0;
`endif
    assign wr_en    = wr_en_q;
    assign wr_addr  = addr_q;
    assign wr_data  = wdata_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = addr_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

`ifndef APB_ARB_TIMEOUT_EN
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule
